// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake toward the issuer.
module serial_subtractor #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic [1:0]       dbg_state
);

   // Handshake: start is honoured only while IDLE (busy=0); operands are captured on that
   // edge. done pulses for one cycle with diff/borrow_out valid; they hold until the next done.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_bw;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;

   logic             w_d;
   logic             w_bw_nxt;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_d       = r_a[0] ^ r_b[0] ^ r_bw;
   assign w_bw_nxt  = (~r_a[0] & r_b[0]) | (~r_a[0] & r_bw) | (r_b[0] & r_bw);
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
      dbg_state = r_state;
   end

   // Result is assembled in r_res and only published to r_diff on the final bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a          <= '0;
         r_b          <= '0;
         r_bw         <= 1'b0;
         r_cnt        <= '0;
         r_res        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_bw  <= borrow_in;
                  r_cnt <= '0;
                  r_res <= '0;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_bw  <= w_bw_nxt;
               r_res <= w_res_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_diff       <= w_res_nxt;
                  r_borrow_out <= w_bw_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=4 main instance plus a WIDTH=8 instance.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, borrow_in;
   logic [3:0] a, b;
   logic       busy, done, borrow_out;
   logic [3:0] diff;
   logic [1:0] dbg_state;

   logic       start8, borrow_in8;
   logic [7:0] a8, b8;
   logic       busy8, done8, borrow_out8;
   logic [7:0] diff8;
   logic [1:0] dbg_state8;

   int n_assert = 0;
   int n_fail   = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .dbg_state(dbg_state)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .borrow_in(borrow_in8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow_out8),
      .dbg_state(dbg_state8)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                      input logic [3:0] ediff, input logic ebo, input string tag);
      logic [3:0] prev;
      int cyc;
      @(negedge clk);
      a = ta; b = tb; borrow_in = tbin; start = 1'b1;
      prev = diff;
      @(posedge clk); #1;
      start = 1'b0;
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      borrow_in = 1'($urandom_range(0, 1));
      chk({tag, "/busy_run"}, 16'(busy), 16'd1);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (!done) chk({tag, "/hold"}, 16'(diff), 16'(prev));
      end
      chk({tag, "/latency"}, 16'(cyc), 16'd4);
      chk({tag, "/diff"}, 16'(diff), 16'(ediff));
      chk({tag, "/borrow"}, 16'(borrow_out), 16'(ebo));
      chk({tag, "/busy_done"}, 16'(busy), 16'd1);
      @(posedge clk); #1;
      chk({tag, "/done_off"}, 16'(done), 16'd0);
      chk({tag, "/idle"}, 16'(busy), 16'd0);
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic [7:0] ediff, input logic ebo, input string tag);
      int cyc;
      @(negedge clk);
      a8 = ta; b8 = tb; borrow_in8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
      cyc = 0;
      while (!done8 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "/latency"}, 16'(cyc), 16'd8);
      chk({tag, "/diff"}, 16'(diff8), 16'(ediff));
      chk({tag, "/borrow"}, 16'(borrow_out8), 16'(ebo));
      @(posedge clk); #1;
      chk({tag, "/done_off"}, 16'(done8), 16'd0);
   endtask

   initial begin
      logic [4:0] e;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; borrow_in8 = 1'b0;
      #12;
      chk("rst/busy", 16'(busy), 16'd0);
      chk("rst/done", 16'(done), 16'd0);
      chk("rst/diff", 16'(diff), 16'd0);
      chk("rst/borrow", 16'(borrow_out), 16'd0);
      chk("rst/state", 16'(dbg_state), 16'd0);
      @(negedge clk); reset = 1'b0;

      // Directed vectors, expectations worked by hand.
      op4(4'd9,  4'd3,  1'b0, 4'b0110, 1'b0, "t1");
      op4(4'd3,  4'd8,  1'b0, 4'b1011, 1'b1, "t2");
      op4(4'd0,  4'd0,  1'b1, 4'b1111, 1'b1, "t3a");
      op4(4'd15, 4'd15, 1'b0, 4'b0000, 1'b0, "t3b");

      // start held high: accepts land every WIDTH+2 = 6 cycles.
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         start = 1'b1;
         a = 4'((k * 5 + 3) % 16); b = 4'((k * 7 + 1) % 16); borrow_in = 1'(k % 2);
         if (k % 6 == 0) exp_q.push_back(5'(a) - 5'(b) - 5'(borrow_in));
         @(posedge clk); #1;
         chk("t4/busy", 16'(busy), 16'(k % 6 != 5));
         chk("t4/done", 16'(done), 16'(k % 6 == 4));
         if (k % 6 == 4 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("t4/diff", 16'(diff), 16'(e[3:0]));
            chk("t4/borrow", 16'(borrow_out), 16'(e[4]));
         end
      end
      start = 1'b0;

      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               e = 5'(ia) - 5'(ib) - 5'(ic);
               op4(4'(ia), 4'(ib), 1'(ic), e[3:0], e[4], "t6");
            end

      // Reset two bits into an op; last op left diff=15, borrow=1.
      @(negedge clk);
      a = 4'd10; b = 4'd4; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t5/busy", 16'(busy), 16'd0);
      chk("t5/done", 16'(done), 16'd0);
      chk("t5/diff", 16'(diff), 16'd0);
      chk("t5/borrow", 16'(borrow_out), 16'd0);
      chk("t5/state", 16'(dbg_state), 16'd0);
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("t5/no_done", 16'(done), 16'd0);
         chk("t5/no_busy", 16'(busy), 16'd0);
      end
      op4(4'd12, 4'd5, 1'b0, 4'b0111, 1'b0, "t5b");

      op8(8'd200, 8'd57, 8'd143, 1'b0, "w8a");
      op8(8'd57, 8'd200, 8'd113, 1'b1, "w8b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
